fp16_operand_join: RTL and testbench

FP16_OPERAND_JOIN -- requirements
Module: fp16_operand_join

---
 rtl/fp16_operand_join.sv | 83 ++++++++
 tb/tb_fp16_operand_join.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_operand_join.sv
// Pairs two independently-valid operand streams into (a, b) beats with a common valid.
// Each channel is a small FIFO; a pair is released only when both heads exist.
module fp16_operand_join #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_axis_a_tdata,
  input  logic                     s_axis_a_tvalid,
  output logic                     s_axis_a_tready,
  input  logic [DATA_W-1:0]        s_axis_b_tdata,
  input  logic                     s_axis_b_tvalid,
  output logic                     s_axis_b_tready,
  output logic [DATA_W-1:0]        m_axis_a_tdata,
  output logic [DATA_W-1:0]        m_axis_b_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   a_level,
  output logic [$clog2(DEPTH):0]   b_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PW-1:0]     a_wr, a_rd, b_wr, b_rd;
  logic              push_a, push_b, pop;

  // Ready comes from the registered level only, so a pop cannot free a slot in the same cycle.
  assign s_axis_a_tready = (a_level < LVL_FULL);
  assign s_axis_b_tready = (b_level < LVL_FULL);

  assign push_a = s_axis_a_tvalid & s_axis_a_tready;
  assign push_b = s_axis_b_tvalid & s_axis_b_tready;
  assign pop    = (a_level != '0) & (b_level != '0) & (~m_axis_tvalid | m_axis_tready);

  always_ff @(posedge aclk) begin
    if (!rst && push_a) mem_a[a_wr] <= s_axis_a_tdata;
    if (!rst && push_b) mem_b[b_wr] <= s_axis_b_tdata;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      a_wr           <= '0;
      a_rd           <= '0;
      b_wr           <= '0;
      b_rd           <= '0;
      a_level        <= '0;
      b_level        <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_a_tdata <= '0;
      m_axis_b_tdata <= '0;
    end else begin
      if (push_a) a_wr <= a_wr + 1'b1;
      if (push_b) b_wr <= b_wr + 1'b1;

      if (pop) begin
        a_rd           <= a_rd + 1'b1;
        b_rd           <= b_rd + 1'b1;
        m_axis_a_tdata <= mem_a[a_rd];
        m_axis_b_tdata <= mem_b[b_rd];
        m_axis_tvalid  <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid  <= 1'b0;
      end

      case ({push_a, pop})
        2'b10:   a_level <= a_level + 1'b1;
        2'b01:   a_level <= a_level - 1'b1;
        default: ;
      endcase

      case ({push_b, pop})
        2'b10:   b_level <= b_level + 1'b1;
        2'b01:   b_level <= b_level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_operand_join.sv
// Directed and randomized checks of the operand pairing stage.
module tb_fp16_operand_join;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NSTR  = 2000;

  logic          aclk = 1'b0;
  logic          rst;
  logic [DW-1:0] ad, bd;
  logic          av, bv;
  logic          a_tready, b_tready;
  logic [DW-1:0] m_a, m_b;
  logic          mv, mr;
  logic [2:0]    a_lvl, b_lvl;

  int total = 0;
  int bad   = 0;

  logic [31:0] out_q [$];
  logic [DW-1:0] sa [NSTR];
  logic [DW-1:0] sb [NSTR];

  typedef struct {
    logic          av;
    logic [DW-1:0] ad;
    logic          bv;
    logic [DW-1:0] bd;
    logic          mr;
    logic          e_mv;
    logic [DW-1:0] e_ma;
    logic [DW-1:0] e_mb;
    logic [2:0]    e_al;
    logic [2:0]    e_bl;
  } vec_t;

  vec_t vecs [13];

  fp16_operand_join #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .aclk            (aclk),
    .rst             (rst),
    .s_axis_a_tdata  (ad),
    .s_axis_a_tvalid (av),
    .s_axis_a_tready (a_tready),
    .s_axis_b_tdata  (bd),
    .s_axis_b_tvalid (bv),
    .s_axis_b_tready (b_tready),
    .m_axis_a_tdata  (m_a),
    .m_axis_b_tdata  (m_b),
    .m_axis_tvalid   (mv),
    .m_axis_tready   (mr),
    .a_level         (a_lvl),
    .b_level         (b_lvl)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk)
    if (!rst && mv && mr) out_q.push_back({m_a, m_b});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    av = 1'b0;
    bv = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ia, ib, mism, c;

    // aligned pair, skewed pair, then special encodings back to back
    vecs[0]  = '{1'b1, 16'h0F00, 1'b1, 16'h0B80, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0F00, 16'h0B80, 3'd0, 3'd0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[3]  = '{1'b1, 16'hD98D, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h4F08, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hD98D, 16'h4F08, 3'd0, 3'd0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[9]  = '{1'b1, 16'h7E01, 1'b1, 16'h8000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd1, 3'd1};
    vecs[10] = '{1'b1, 16'h7C00, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h7E01, 16'h8000, 3'd1, 3'd1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h7C00, 16'h0001, 3'd0, 3'd0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0};

    rst = 1'b1;
    mr  = 1'b1;
    ad  = '0;
    bd  = '0;
    idle();
    repeat (2) @(negedge aclk);
    chk("rst_mv", mv, 0);
    chk("rst_ma", m_a, 0);
    chk("rst_mb", m_b, 0);
    chk("rst_al", a_lvl, 0);
    chk("rst_bl", b_lvl, 0);
    chk("rst_ardy", a_tready, 1);
    chk("rst_brdy", b_tready, 1);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      av = vecs[i].av; ad = vecs[i].ad;
      bv = vecs[i].bv; bd = vecs[i].bd;
      mr = vecs[i].mr;
      @(negedge aclk);
      chk($sformatf("vec%0d_mv", i), mv, vecs[i].e_mv);
      if (vecs[i].e_mv) begin
        chk($sformatf("vec%0d_ma", i), m_a, vecs[i].e_ma);
        chk($sformatf("vec%0d_mb", i), m_b, vecs[i].e_mb);
      end
      chk($sformatf("vec%0d_al", i), a_lvl, vecs[i].e_al);
      chk($sformatf("vec%0d_bl", i), b_lvl, vecs[i].e_bl);
      chk($sformatf("vec%0d_ardy", i), a_tready, 32'(vecs[i].e_al < 3'd4));
      chk($sformatf("vec%0d_brdy", i), b_tready, 32'(vecs[i].e_bl < 3'd4));
    end
    idle();

    // fill channel A, hold a fifth word, then release with one B
    out_q.delete();
    for (int k = 0; k < 4; k++) begin
      av = 1'b1; ad = 16'h1001 + 16'(k);
      @(negedge aclk);
      chk($sformatf("full_al%0d", k), a_lvl, k + 1);
    end
    chk("full_ardy0", a_tready, 0);
    ad = 16'h1005;
    @(negedge aclk);
    chk("full_hold_al", a_lvl, 4);
    bv = 1'b1; bd = 16'h3400;
    @(negedge aclk);
    chk("full_bpush_al", a_lvl, 4);
    chk("full_bpush_bl", b_lvl, 1);
    chk("full_bpush_ardy", a_tready, 0);
    bv = 1'b0;
    @(negedge aclk);
    chk("full_pop_mv", mv, 1);
    chk("full_pop_ma", m_a, 16'h1001);
    chk("full_pop_mb", m_b, 16'h3400);
    chk("full_pop_al", a_lvl, 3);
    chk("full_pop_ardy", a_tready, 1);
    @(negedge aclk);
    chk("full_refill_al", a_lvl, 4);
    av = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bv = 1'b1; bd = 16'h3400 + 16'(k);
      @(negedge aclk);
    end
    bv = 1'b0;
    repeat (3) @(negedge aclk);
    chk("full_count", out_q.size(), 5);
    for (int k = 0; k < 5 && k < out_q.size(); k++)
      chk($sformatf("full_out%0d", k), out_q[k], {16'h1001 + 16'(k), 16'h3400 + 16'(k)});

    // backpressure with three pairs buffered
    mr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      av = 1'b1; ad = 16'h2001 + 16'(k);
      bv = 1'b1; bd = 16'h2101 + 16'(k);
      @(negedge aclk);
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk($sformatf("bp_hold_mv%0d", k), mv, 1);
      chk($sformatf("bp_hold_ma%0d", k), m_a, 16'h2001);
      chk($sformatf("bp_hold_mb%0d", k), m_b, 16'h2101);
      chk($sformatf("bp_hold_al%0d", k), a_lvl, 2);
    end
    mr = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge aclk);
      chk($sformatf("bp_rel_mv%0d", k), mv, 1);
      chk($sformatf("bp_rel_ma%0d", k), m_a, 16'h2001 + 16'(k));
      chk($sformatf("bp_rel_mb%0d", k), m_b, 16'h2101 + 16'(k));
    end
    @(negedge aclk);
    chk("bp_end_mv", mv, 0);
    chk("bp_end_al", a_lvl, 0);

    // back-to-back pairs, one per cycle
    for (int k = 0; k < 8; k++) begin
      av = 1'b1; ad = 16'h3000 + 16'(k);
      bv = 1'b1; bd = 16'h3100 + 16'(k);
      @(negedge aclk);
      if (k >= 1) begin
        chk($sformatf("tp_mv%0d", k), mv, 1);
        chk($sformatf("tp_ma%0d", k), m_a, 16'h3000 + 16'(k - 1));
        chk($sformatf("tp_al%0d", k), a_lvl, 1);
      end
    end
    idle();
    repeat (3) @(negedge aclk);

    // reset with 2 A and 1 B buffered
    out_q.delete();
    av = 1'b1; ad = 16'h5001;
    @(negedge aclk);
    ad = 16'h5002; bv = 1'b1; bd = 16'h5101;
    @(negedge aclk);
    chk("mrst_pre_al", a_lvl, 2);
    chk("mrst_pre_bl", b_lvl, 1);
    rst = 1'b1; ad = 16'h5003; bd = 16'h5102;
    @(negedge aclk);
    chk("mrst_al", a_lvl, 0);
    chk("mrst_bl", b_lvl, 0);
    chk("mrst_mv", mv, 0);
    chk("mrst_ma", m_a, 0);
    chk("mrst_ardy", a_tready, 1);
    rst = 1'b0; ad = 16'h6001; bd = 16'h6101;
    @(negedge aclk);
    idle();
    repeat (4) @(negedge aclk);
    chk("mrst_count", out_q.size(), 1);
    if (out_q.size() > 0) chk("mrst_out", out_q[0], {16'h6001, 16'h6101});

    // randomized stream with independent per-channel gaps
    for (int k = 0; k < NSTR; k++) begin
      sa[k] = 16'($urandom);
      sb[k] = 16'($urandom);
    end
    out_q.delete();
    mr = 1'b1;
    ia = 0;
    ib = 0;
    fork
      begin
        logic hs_a;
        for (int cy = 0; cy < 20000 && ia < NSTR; cy++) begin
          av = ($urandom_range(0, 3) != 0);
          ad = sa[ia];
          hs_a = av && a_tready;
          @(negedge aclk);
          if (hs_a) ia++;
        end
        av = 1'b0;
      end
      begin
        logic hs_b;
        for (int cy = 0; cy < 20000 && ib < NSTR; cy++) begin
          bv = ($urandom_range(0, 2) != 0);
          bd = sb[ib];
          hs_b = bv && b_tready;
          @(negedge aclk);
          if (hs_b) ib++;
        end
        bv = 1'b0;
      end
    join
    chk("stream_a_sent", ia, NSTR);
    chk("stream_b_sent", ib, NSTR);
    c = 0;
    while (c < 100 && out_q.size() < NSTR) begin
      @(negedge aclk);
      c++;
    end
    repeat (3) @(negedge aclk);
    chk("stream_count", out_q.size(), NSTR);
    mism = 0;
    for (int k = 0; k < NSTR && k < out_q.size(); k++)
      if (out_q[k] !== {sa[k], sb[k]}) mism++;
    chk("stream_mismatches", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
